// File: rtl/pmu_pkg.sv
// Shared PMU parameters and sequencer state encoding.
// Also imported by the lane-serial PMU wrapper.
package pmu_pkg;

    localparam int NUM_LANES  = 240;
    localparam int DATA_WIDTH = 16;
    localparam int OUT_W      = DATA_WIDTH + 1;
    localparam int PMU_LAT    = 2;

    localparam int LANE_W = $clog2(NUM_LANES + 1);
    localparam int WAIT_W = $clog2(PMU_LAT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_DRAIN
    } seq_state_t;

endpackage

// File: rtl/pmu_batch_sequencer_if.sv
// Host-side operand stream in, result stream out.
// master = host DMA, slave = batch sequencer.
interface pmu_batch_sequencer_if
    import pmu_pkg::*;
;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  in_last;

    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic                  out_last;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/pmu_batch_sequencer.sv
// Paces one PMU batch through the lane-serial wrapper:
// clear, load NUM_LANES pairs, settle, capture, drain.
module pmu_batch_sequencer
    import pmu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    pmu_batch_sequencer_if.slave  bus,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  wr_rst,
    output logic                  wr_load_en,
    output logic [DATA_WIDTH-1:0] wr_dina,
    output logic [DATA_WIDTH-1:0] wr_dinb,
    output logic                  wr_compute_start,
    output logic                  wr_read_en,
    input  logic [OUT_W-1:0]      wr_dout
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(PMU_LAT);

    seq_state_t        state, state_next;
    logic [LANE_W-1:0] lane_cnt, lane_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              err_next;
    logic              on_last;

    assign on_last  = (lane_cnt == LAST_LANE);
    assign busy     = (state != S_IDLE);
    assign wr_rst   = rst | (state == S_CLEAR);
    assign wr_dina  = bus.in_a;
    assign wr_dinb  = bus.in_b;
    assign bus.out_data = wr_dout;
    assign bus.out_last = (state == S_DRAIN) && on_last;

    // State, counters and sticky framing flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            lane_cnt  <= '0;
            wait_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            lane_cnt  <= lane_next;
            wait_cnt  <= wait_next;
            frame_err <= err_next;
        end
    end

    // Next-state, counter updates and wrapper strobes.
    always_comb begin
        state_next       = state;
        lane_next        = lane_cnt;
        wait_next        = wait_cnt;
        err_next         = frame_err;
        bus.in_ready     = 1'b0;
        bus.out_valid    = 1'b0;
        wr_load_en       = 1'b0;
        wr_compute_start = 1'b0;
        wr_read_en       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CLEAR;
                    err_next   = 1'b0;
                end
            end
            S_CLEAR: begin
                lane_next  = '0;
                state_next = S_LOAD;
            end
            S_LOAD: begin
                bus.in_ready = 1'b1;
                wr_load_en   = bus.in_valid;
                if (bus.in_valid) begin
                    // in_last is only a framing check; the lane count rules.
                    if (bus.in_last != on_last)
                        err_next = 1'b1;
                    lane_next = lane_cnt + LANE_W'(1);
                    if (on_last) begin
                        wait_next  = '0;
                        state_next = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                // One cycle for the store write plus PMU_LAT pipeline.
                if (wait_cnt == LAST_WAIT)
                    state_next = S_CAPTURE;
                else
                    wait_next = wait_cnt + WAIT_W'(1);
            end
            S_CAPTURE: begin
                wr_compute_start = 1'b1;
                lane_next        = '0;
                state_next       = S_DRAIN;
            end
            S_DRAIN: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    // Wrapper read index saturates; no advance on the last lane.
                    if (on_last) begin
                        state_next = S_IDLE;
                    end else begin
                        wr_read_en = 1'b1;
                        lane_next  = lane_cnt + LANE_W'(1);
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pmu_batch_sequencer.sv
// Bench for pmu_batch_sequencer with a behavioural wrapper
// stand-in and an A+B per-lane reference.
module tb_pmu_batch_sequencer
    import pmu_pkg::*;
;

    localparam int N = NUM_LANES;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, frame_err;
    logic wr_rst, wr_load_en, wr_compute_start, wr_read_en;
    logic [DATA_WIDTH-1:0] wr_dina, wr_dinb;
    logic [OUT_W-1:0] wr_dout;

    pmu_batch_sequencer_if bus ();

    pmu_batch_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .bus              (bus.slave),
        .busy             (busy),
        .frame_err        (frame_err),
        .wr_rst           (wr_rst),
        .wr_load_en       (wr_load_en),
        .wr_dina          (wr_dina),
        .wr_dinb          (wr_dinb),
        .wr_compute_start (wr_compute_start),
        .wr_read_en       (wr_read_en),
        .wr_dout          (wr_dout)
    );

    always #5 clk = ~clk;

    // Wrapper stand-in: saturating indices, no back-pressure.
    logic [DATA_WIDTH-1:0] st_a [N];
    logic [DATA_WIDTH-1:0] st_b [N];
    logic [OUT_W-1:0]      res  [N];
    int   wr_idx = 0;
    int   rd_idx = 0;
    logic res_valid = 1'b0;

    always @(posedge clk) begin
        if (wr_rst) begin
            wr_idx    <= 0;
            rd_idx    <= 0;
            res_valid <= 1'b0;
        end else begin
            if (wr_load_en && wr_idx < N) begin
                st_a[wr_idx] <= wr_dina;
                st_b[wr_idx] <= wr_dinb;
                wr_idx       <= wr_idx + 1;
            end
            if (wr_compute_start) begin
                for (int i = 0; i < N; i++)
                    res[i] <= {1'b0, st_a[i]} + {1'b0, st_b[i]};
                res_valid <= 1'b1;
            end
            if (wr_read_en && rd_idx < N - 1)
                rd_idx <= rd_idx + 1;
        end
    end

    always_comb wr_dout = res_valid ? res[rd_idx] : '0;

    // Strobe monitors: cumulative counts and capture spacing.
    int cyc = 0, n_loads = 0, n_reads = 0, n_caps = 0;
    int last_load = 0, cap_gap = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_load_en) begin
            n_loads   <= n_loads + 1;
            last_load <= cyc;
        end
        if (wr_read_en)
            n_reads <= n_reads + 1;
        if (wr_compute_start) begin
            n_caps  <= n_caps + 1;
            cap_gap <= cyc - last_load;
        end
    end

    // Reference model: host data and per-lane sums.
    logic [DATA_WIDTH-1:0] va [N];
    logic [DATA_WIDTH-1:0] vb [N];
    logic [OUT_W-1:0]      ex [N];
    int n_tests = 0;
    int n_fail  = 0;
    int s_loads, s_reads, s_caps;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: begin va[i] = DATA_WIDTH'(i); vb[i] = DATA_WIDTH'(2 * i); end
                1: begin va[i] = 16'hFFFF; vb[i] = 16'hFFFF; end
                2: begin va[i] = 16'd7; vb[i] = 16'd1; end
                default: begin
                    va[i] = DATA_WIDTH'($urandom);
                    vb[i] = DATA_WIDTH'($urandom);
                end
            endcase
            ex[i] = OUT_W'(va[i]) + OUT_W'(vb[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wr_rst", wr_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_batch();
        @(negedge clk);
        #1;
        chk("pre_start_busy", busy, 0);
        start = 1'b1;
        s_loads = n_loads;
        s_reads = n_reads;
        s_caps  = n_caps;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("clear_busy", busy, 1);
        chk("clear_wr_rst", wr_rst, 1);
        chk("clear_frame_err", frame_err, 0);
    endtask

    task automatic load_batch(input int vpct, input int bad_lane,
                              input int abort_at, input bit poke);
        int lane = 0;
        int budget = 0;
        while (lane < N && lane != abort_at && budget < 20000) begin
            @(negedge clk);
            bus.in_valid = ($urandom_range(99) < vpct);
            bus.in_a     = va[lane];
            bus.in_b     = vb[lane];
            bus.in_last  = (lane == N - 1) || (lane == bad_lane);
            start        = poke && (lane == 60);
            #1;
            if (bus.in_valid && bus.in_ready)
                lane++;
            budget++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        start        = 1'b0;
        if (abort_at < 0)
            chk("load_count", lane, N);
    endtask

    task automatic drain_batch(input int rpct, input int abort_at,
                               input bit poke_end);
        int lane = 0;
        int budget = 0;
        logic stalled = 1'b0;
        logic [OUT_W-1:0] held = '0;
        while (lane < N && lane != abort_at && budget < 20000) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(99) < rpct);
            if (poke_end && lane == N - 1) begin
                bus.out_ready = 1'b1;
                start = 1'b1;
            end
            #1;
            if (bus.out_valid) begin
                chk("out_data", bus.out_data, ex[lane]);
                chk("out_last", bus.out_last, lane == N - 1);
                if (stalled)
                    chk("stall_hold", bus.out_data, held);
                stalled = !bus.out_ready;
                held    = bus.out_data;
                if (bus.out_ready)
                    lane++;
            end else begin
                stalled = 1'b0;
            end
            budget++;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        start = 1'b0;
        if (abort_at < 0)
            chk("drain_count", lane, N);
    endtask

    task automatic end_checks(input bit err_exp);
        #1;
        chk("end_busy", busy, 0);
        chk("end_frame_err", frame_err, err_exp);
        chk("loads", n_loads - s_loads, N);
        chk("reads", n_reads - s_reads, N - 1);
        chk("captures", n_caps - s_caps, 1);
        // Last load edge, PMU_LAT+1 settle cycles, then the capture edge.
        chk("capture_gap", cap_gap, PMU_LAT + 2);
    endtask

    task automatic full_batch(input int vpct, input int rpct);
        start_batch();
        load_batch(vpct, -1, -1, 1'b0);
        drain_batch(rpct, -1, 1'b0);
        end_checks(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_last", bus.out_last, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_load_en", wr_load_en, 0);
        chk("reset_compute", wr_compute_start, 0);
        chk("reset_read_en", wr_read_en, 0);
        chk("reset_wr_rst", wr_rst, 1);
        @(negedge clk);
        rst = 1'b0;

        // Full-rate ramp data.
        set_data(0);
        full_batch(100, 100);

        // Random data with random stalls on both sides.
        set_data(3);
        full_batch(50, 30);

        // Maximum operands.
        set_data(1);
        full_batch(100, 100);

        // Early in_last at lane 100: sticky error, full batch still loaded.
        set_data(3);
        start_batch();
        load_batch(100, 100, -1, 1'b0);
        #1;
        chk("frame_err_set", frame_err, 1);
        drain_batch(100, -1, 1'b0);
        end_checks(1'b1);

        // Next start clears the error; reset aborts at lane 120.
        set_data(3);
        start_batch();
        load_batch(70, -1, 120, 1'b0);
        do_reset();
        set_data(2);
        full_batch(100, 100);

        // Reset in the middle of a drain.
        set_data(3);
        start_batch();
        load_batch(100, -1, -1, 1'b0);
        drain_batch(60, 50, 1'b0);
        do_reset();
        set_data(3);
        full_batch(80, 80);

        // Start during LOAD and on the final drain handshake is ignored.
        set_data(3);
        start_batch();
        load_batch(60, -1, -1, 1'b1);
        drain_batch(70, -1, 1'b1);
        end_checks(1'b0);
        set_data(3);
        full_batch(60, 60);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
